// File: rtl/pc_sequence_ctrl_if.sv
// Bundle of sequencing-controller signals between the CPU datapath and the PC controller.
// i_* are driven toward the controller, o_* are produced by it.
interface pc_sequence_ctrl_if #(
  parameter int NrOfBits = 32
);
  logic                i_go;
  logic                i_step_mode;
  logic                i_halt;
  logic                i_branch_taken;
  logic                i_jalr;
  logic                i_uret;
  logic [NrOfBits-1:0] i_branch_target;
  logic [NrOfBits-1:0] i_jalr_target;
  logic [2:0]          i_irq_req;
  logic                i_irq_enable;
  logic [NrOfBits-1:0] i_pc_q;
  logic [NrOfBits-1:0] o_pc_d;
  logic                o_pc_en;
  logic                o_commit;
  logic [NrOfBits-1:0] o_epc;
  logic [2:0]          o_irq_ack;
  logic [2:0]          o_in_service;
  logic                o_halted;
  logic [31:0]         o_retire_count;

  modport master (
    output i_go, i_step_mode, i_halt, i_branch_taken, i_jalr, i_uret,
           i_branch_target, i_jalr_target, i_irq_req, i_irq_enable, i_pc_q,
    input  o_pc_d, o_pc_en, o_commit, o_epc, o_irq_ack, o_in_service,
           o_halted, o_retire_count
  );

  modport slave (
    input  i_go, i_step_mode, i_halt, i_branch_taken, i_jalr, i_uret,
           i_branch_target, i_jalr_target, i_irq_req, i_irq_enable, i_pc_q,
    output o_pc_d, o_pc_en, o_commit, o_epc, o_irq_ack, o_in_service,
           o_halted, o_retire_count
  );
endinterface

// File: rtl/pc_sequence_ctrl.sv
// PC sequencing controller: next-PC select, halt/step control, nested vectored
// interrupts with an EPC stack and uret return, and a retired-instruction counter.
module pc_sequence_ctrl #(
  parameter int                  NrOfBits    = 32,
  parameter logic [NrOfBits-1:0] IrqBase     = NrOfBits'('h100),
  parameter logic [NrOfBits-1:0] IrqStride   = NrOfBits'('h10),
  parameter bit                  StartHalted = 1'b0
) (
  input logic               i_clk,
  input logic               i_rst_n,
  pc_sequence_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_HALTED = 2'b01,
    S_STEP   = 2'b10
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [2:0]               r_pending, r_in_service, r_irq_prev;
  logic [2:0][NrOfBits-1:0] r_epc_stk;
  logic [1:0]               r_depth;
  logic [31:0]              r_retire;

  logic                w_commit, w_accept, w_pop, w_pend_any, w_isv_any;
  logic [1:0]          w_pend_hi, w_isv_hi;
  logic [2:0]          w_edge, w_ack, w_isv_clr;
  logic [NrOfBits-1:0] w_epc_top, w_pc_seq, w_vector;

  assign w_commit = (r_state == S_RUN || r_state == S_STEP) && i_rst_n;
  assign w_edge   = bus.i_irq_req & ~r_irq_prev;

  // Highest-index encoders for pending and in-service levels
  always_comb begin
    w_pend_any = |r_pending;
    w_pend_hi  = r_pending[2] ? 2'd2 : (r_pending[1] ? 2'd1 : 2'd0);
    w_isv_any  = |r_in_service;
    w_isv_hi   = r_in_service[2] ? 2'd2 : (r_in_service[1] ? 2'd1 : 2'd0);
    w_isv_clr  = '0;
    if (w_isv_any) w_isv_clr[w_isv_hi] = 1'b1;
  end

  assign w_epc_top = (r_depth == 2'd0) ? '0 : r_epc_stk[r_depth - 2'd1];
  assign w_pop     = w_commit && bus.i_uret && (r_depth != 2'd0);
  assign w_accept  = w_commit && bus.i_irq_enable && !bus.i_uret && !bus.i_halt &&
                     w_pend_any && (!w_isv_any || (w_pend_hi > w_isv_hi));
  assign w_vector  = IrqBase + NrOfBits'(w_pend_hi) * IrqStride;

  // Next PC ignoring interrupts; this is also what gets pushed on accept
  always_comb begin
    w_pc_seq = bus.i_pc_q + NrOfBits'(4);
    if (w_pop)                    w_pc_seq = w_epc_top;
    else if (bus.i_jalr)          w_pc_seq = {bus.i_jalr_target[NrOfBits-1:1], 1'b0};
    else if (bus.i_branch_taken)  w_pc_seq = bus.i_branch_target;
  end

  always_comb begin
    w_ack = '0;
    if (w_accept) w_ack[w_pend_hi] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (bus.i_halt) w_state_nxt = S_HALTED;
      S_HALTED: if (bus.i_go)   w_state_nxt = bus.i_step_mode ? S_STEP : S_RUN;
      S_STEP:   w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_HALTED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StartHalted ? S_HALTED : S_RUN;
      r_pending    <= '0;
      r_in_service <= '0;
      r_irq_prev   <= '0;
      r_epc_stk    <= '0;
      r_depth      <= '0;
      r_retire     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= bus.i_irq_req;
      // A fresh edge on the level being acknowledged keeps it pending
      r_pending  <= (r_pending & ~w_ack) | w_edge;
      if (w_accept) begin
        r_epc_stk[r_depth] <= w_pc_seq;
        r_depth            <= r_depth + 2'd1;
        r_in_service       <= r_in_service | w_ack;
      end else if (w_pop) begin
        r_depth      <= r_depth - 2'd1;
        r_in_service <= r_in_service & ~w_isv_clr;
      end
      if (w_commit) r_retire <= r_retire + 32'd1;
    end
  end

  assign bus.o_pc_d         = !w_commit ? bus.i_pc_q : (w_accept ? w_vector : w_pc_seq);
  assign bus.o_pc_en        = w_commit;
  assign bus.o_commit       = w_commit;
  assign bus.o_epc          = w_epc_top;
  assign bus.o_irq_ack      = w_ack;
  assign bus.o_in_service   = r_in_service;
  assign bus.o_halted       = (r_state == S_HALTED);
  assign bus.o_retire_count = r_retire;
endmodule
